// File: rtl/spec_free_list_pkg.sv
// Shared sizing, types and pointer arithmetic for the speculative physical-register free list.
package spec_free_list_pkg;

    localparam int SIZE_PHYSICAL_TABLE = 96;
    localparam int SIZE_PHYSICAL_LOG   = 7;
    localparam int SIZE_RMT            = 32;
    localparam int SIZE_FREE_LIST      = SIZE_PHYSICAL_TABLE - SIZE_RMT;
    localparam int SIZE_FREE_LIST_LOG  = 6;
    localparam int COMMIT_WIDTH        = 4;
    localparam int DISPATCH_WIDTH      = 4;

    typedef logic [SIZE_PHYSICAL_LOG-1:0]  phyTag_t;
    typedef logic [SIZE_FREE_LIST_LOG-1:0] flPtr_t;
    typedef logic [SIZE_FREE_LIST_LOG:0]   flCnt_t;

    localparam flCnt_t FL_DEPTH     = flCnt_t'(SIZE_FREE_LIST);
    localparam flCnt_t FL_MIN_AVAIL = flCnt_t'(DISPATCH_WIDTH);

    // Sum-and-conditional-subtract so depths that are not a power of two still wrap correctly.
    function automatic flPtr_t ptrAdd(input flPtr_t base, input logic [2:0] offset);
        flCnt_t sum;
        sum = flCnt_t'(base) + flCnt_t'(offset);
        if (sum >= FL_DEPTH) begin
            sum = sum - FL_DEPTH;
        end else begin
            sum = sum;
        end
        return sum[SIZE_FREE_LIST_LOG-1:0];
    endfunction

endpackage

// File: rtl/spec_free_list_checker.sv
// Run-time invariants for the free list: occupancy bound and pop compaction consistency.
module spec_free_list_checker
    import spec_free_list_pkg::*;
(
    input logic            clk,
    input logic            reset,
    input flCnt_t          countRaw,
    input logic [3:0]      reqVec,
    input logic [3:0][1:0] popOffsets,
    input logic [2:0]      reqCnt
);

    assert property (@(posedge clk) disable iff (!reset) countRaw <= FL_DEPTH);

    for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : gOffChk
        assert property (@(posedge clk) disable iff (!reset)
                         reqVec[k] |-> ({1'b0, popOffsets[k]} < reqCnt));
    end

endmodule

// File: rtl/spec_free_list_compact4.sv
// Four-slot compactor: prefix count of lower valid bits per slot, plus total valid count.
module free_list_compact4 (
    input  logic [3:0]      validVec,
    output logic [3:0][1:0] offsets,
    output logic [2:0]      total
);

    // Each slot lands at the number of valid slots below it.
    always_comb begin
        offsets[0] = 2'd0;
        offsets[1] = {1'b0, validVec[0]};
        offsets[2] = {1'b0, validVec[0]} + {1'b0, validVec[1]};
        offsets[3] = offsets[2] + {1'b0, validVec[2]};
        total      = {1'b0, offsets[3]} + {2'b00, validVec[3]};
    end

endmodule

// File: rtl/spec_free_list.sv
// Speculative physical-register free list: circular tag buffer, 4 pushes and 4 pops per cycle,
// single-cycle restore of the full free set on recovery.
module spec_free_list
    import spec_free_list_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          releasedValid0_i,
    input  logic                          releasedValid1_i,
    input  logic                          releasedValid2_i,
    input  logic                          releasedValid3_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap0_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap1_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap2_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap3_i,
    input  logic                          reqFreeReg0_i,
    input  logic                          reqFreeReg1_i,
    input  logic                          reqFreeReg2_i,
    input  logic                          reqFreeReg3_i,
    input  logic                          recoverFlag_i,
    output logic [SIZE_PHYSICAL_LOG-1:0]  freeReg0_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]  freeReg1_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]  freeReg2_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]  freeReg3_o,
    output logic                          freeListEmpty_o,
    output logic [SIZE_FREE_LIST_LOG:0]   freeCount_o
);

    phyTag_t         buf_r [SIZE_FREE_LIST];
    flPtr_t          head_r;
    flPtr_t          tail_r;
    flCnt_t          count_r;
    logic            empty_r;

    flPtr_t          headNext_s;
    flPtr_t          tailNext_s;
    flCnt_t          countNext_s;
    flCnt_t          countRaw_s;
    logic            emptyNext_s;

    logic [3:0]      pushVec_s;
    logic [3:0]      reqVec_s;
    logic [3:0][1:0] pushOff_s;
    logic [3:0][1:0] popOff_s;
    logic [2:0]      pushCnt_s;
    logic [2:0]      reqCnt_s;
    logic [2:0]      popCnt_s;
    phyTag_t         relTag_s [COMMIT_WIDTH];
    flPtr_t          wrAddr_s [COMMIT_WIDTH];
    phyTag_t         rdTag_s  [DISPATCH_WIDTH];

    assign pushVec_s   = {releasedValid3_i, releasedValid2_i, releasedValid1_i, releasedValid0_i};
    assign reqVec_s    = {reqFreeReg3_i, reqFreeReg2_i, reqFreeReg1_i, reqFreeReg0_i};
    assign relTag_s[0] = releasedPhyMap0_i;
    assign relTag_s[1] = releasedPhyMap1_i;
    assign relTag_s[2] = releasedPhyMap2_i;
    assign relTag_s[3] = releasedPhyMap3_i;

    free_list_compact4 u_pushCompact (
        .validVec (pushVec_s),
        .offsets  (pushOff_s),
        .total    (pushCnt_s)
    );

    free_list_compact4 u_popCompact (
        .validVec (reqVec_s),
        .offsets  (popOff_s),
        .total    (reqCnt_s)
    );

    // Next pointers and occupancy; pops are dropped while stalled or recovering.
    always_comb begin
        if (empty_r || recoverFlag_i) begin
            popCnt_s = 3'd0;
        end else begin
            popCnt_s = reqCnt_s;
        end
        tailNext_s  = ptrAdd(tail_r, pushCnt_s);
        countRaw_s  = count_r + flCnt_t'(pushCnt_s) - flCnt_t'(popCnt_s);
        if (recoverFlag_i) begin
            headNext_s  = tailNext_s;
            countNext_s = FL_DEPTH;
        end else begin
            headNext_s  = ptrAdd(head_r, popCnt_s);
            countNext_s = countRaw_s;
        end
        emptyNext_s = (countNext_s < FL_MIN_AVAIL);
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            wrAddr_s[k] = ptrAdd(tail_r, {1'b0, pushOff_s[k]});
        end
    end

    // Pointer, occupancy and stall-flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= FL_DEPTH;
            empty_r <= 1'b0;
        end else begin
            head_r  <= headNext_s;
            tail_r  <= tailNext_s;
            count_r <= countNext_s;
            empty_r <= emptyNext_s;
        end
    end

    // Tag storage: reset holds every tag not in the architectural map.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SIZE_FREE_LIST; i++) begin
                buf_r[i] <= phyTag_t'(SIZE_RMT + i);
            end
        end else begin
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (pushVec_s[k]) begin
                    buf_r[wrAddr_s[k]] <= relTag_s[k];
                end
            end
        end
    end

    // Candidate tags read straight from the registered head, each slot wrapping on its own.
    always_comb begin
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            rdTag_s[k] = buf_r[ptrAdd(head_r, 3'(k))];
        end
    end

    assign freeReg0_o      = rdTag_s[0];
    assign freeReg1_o      = rdTag_s[1];
    assign freeReg2_o      = rdTag_s[2];
    assign freeReg3_o      = rdTag_s[3];
    assign freeListEmpty_o = empty_r;
    assign freeCount_o     = count_r;

    spec_free_list_checker u_checker (
        .clk        (clk),
        .reset      (reset),
        .countRaw   (countRaw_s),
        .reqVec     (reqVec_s),
        .popOffsets (popOff_s),
        .reqCnt     (reqCnt_s)
    );

endmodule

// File: tb/tb_spec_free_list.sv
// Directed bench for spec_free_list: ring-buffer reference model compared every cycle,
// plus hand-computed expectations at the key points.
module tb_spec_free_list;

    logic       clk;
    logic       reset;
    logic [3:0] relV;
    logic [6:0] tg [4];
    logic [3:0] reqV;
    logic       recV;
    logic [6:0] freeReg [4];
    logic       freeListEmpty;
    logic [6:0] freeCount;

    int errors = 0;
    int checks = 0;
    bit chkEn  = 1'b0;

    int mbuf [64];
    int mhead, mtail, mcount;

    spec_free_list dut (
        .clk               (clk),
        .reset             (reset),
        .releasedValid0_i  (relV[0]),
        .releasedValid1_i  (relV[1]),
        .releasedValid2_i  (relV[2]),
        .releasedValid3_i  (relV[3]),
        .releasedPhyMap0_i (tg[0]),
        .releasedPhyMap1_i (tg[1]),
        .releasedPhyMap2_i (tg[2]),
        .releasedPhyMap3_i (tg[3]),
        .reqFreeReg0_i     (reqV[0]),
        .reqFreeReg1_i     (reqV[1]),
        .reqFreeReg2_i     (reqV[2]),
        .reqFreeReg3_i     (reqV[3]),
        .recoverFlag_i     (recV),
        .freeReg0_o        (freeReg[0]),
        .freeReg1_o        (freeReg[1]),
        .freeReg2_o        (freeReg[2]),
        .freeReg3_o        (freeReg[3]),
        .freeListEmpty_o   (freeListEmpty),
        .freeCount_o       (freeCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic mReset();
        for (int i = 0; i < 64; i++) mbuf[i] = 32 + i;
        mhead  = 0;
        mtail  = 0;
        mcount = 64;
    endtask

    // One clock of stimulus; the model advances on the same edge from the same inputs.
    task automatic step(input logic [3:0] req, input logic [3:0] rv,
                        input int t0, input int t1, input int t2, input int t3,
                        input logic rec);
        int tt [4];
        int pop;
        int n;
        tt[0] = t0; tt[1] = t1; tt[2] = t2; tt[3] = t3;
        reqV = req;
        relV = rv;
        recV = rec;
        for (int k = 0; k < 4; k++) tg[k] = 7'(tt[k]);
        @(posedge clk);
        pop = 0;
        if (mcount >= 4 && !rec) pop = $countones(req);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (rv[k]) begin
                mbuf[(mtail + n) % 64] = tt[k];
                n++;
            end
        end
        mtail = (mtail + n) % 64;
        if (rec) begin
            mhead  = mtail;
            mcount = 64;
        end else begin
            mhead  = (mhead + pop) % 64;
            mcount = mcount + n - pop;
        end
        #1;
        reqV = 4'h0;
        relV = 4'h0;
        recV = 1'b0;
    endtask

    task automatic pop4();
        step(4'hF, 4'h0, 0, 0, 0, 0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle, released away from the clock edge.
    task automatic doReset();
        #2;
        reset = 1'b0;
        mReset();
        #1;
        check("async_rst_count", int'(freeCount), 64);
        check("async_rst_free0", int'(freeReg[0]), 32);
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    // Per-cycle comparison against the reference model.
    always @(negedge clk) begin
        if (chkEn) begin
            check("model_count", int'(freeCount), mcount);
            check("model_empty", int'(freeListEmpty), (mcount < 4) ? 1 : 0);
            if (mcount >= 4) begin
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("model_free%0d", k), int'(freeReg[k]), mbuf[(mhead + k) % 64]);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        relV  = 4'h0;
        reqV  = 4'h0;
        recV  = 1'b0;
        for (int k = 0; k < 4; k++) tg[k] = 7'd0;
        mReset();
        chkEn = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;

        // Reset state
        check("rst_free0", int'(freeReg[0]), 32);
        check("rst_free1", int'(freeReg[1]), 33);
        check("rst_free2", int'(freeReg[2]), 34);
        check("rst_free3", int'(freeReg[3]), 35);
        check("rst_count", int'(freeCount), 64);
        check("rst_empty", int'(freeListEmpty), 0);

        // Drain to 4, then to 0; further requests ignored
        repeat (15) pop4();
        check("drain15_count", int'(freeCount), 4);
        check("drain15_empty", int'(freeListEmpty), 0);
        check("drain15_free0", int'(freeReg[0]), 92);
        pop4();
        check("drain16_count", int'(freeCount), 0);
        check("drain16_empty", int'(freeListEmpty), 1);
        pop4();
        check("empty_req_count", int'(freeCount), 0);

        // Sparse releases compact from the tail
        step(4'h0, 4'b1010, 0, 5, 0, 9, 1'b0);
        check("rel2_count", int'(freeCount), 2);
        check("rel2_empty", int'(freeListEmpty), 1);
        step(4'h0, 4'b0011, 11, 13, 0, 0, 1'b0);
        check("rel4_free0", int'(freeReg[0]), 5);
        check("rel4_free1", int'(freeReg[1]), 9);
        check("rel4_free2", int'(freeReg[2]), 11);
        check("rel4_free3", int'(freeReg[3]), 13);
        check("rel4_empty", int'(freeListEmpty), 0);

        // Wrap: walk head and tail to 62 with the list full
        doReset();
        for (int i = 0; i < 15; i++) begin
            pop4();
            step(4'h0, 4'hF, 32 + 4*i, 33 + 4*i, 34 + 4*i, 35 + 4*i, 1'b0);
        end
        step(4'b0011, 4'h0, 0, 0, 0, 0, 1'b0);
        step(4'h0, 4'b0011, 92, 93, 0, 0, 1'b0);
        check("wrap_count", int'(freeCount), 64);
        check("wrap_free0", int'(freeReg[0]), 94);
        check("wrap_free1", int'(freeReg[1]), 95);
        check("wrap_free2", int'(freeReg[2]), 32);
        check("wrap_free3", int'(freeReg[3]), 33);
        pop4();
        step(4'h0, 4'b0001, 94, 0, 0, 0, 1'b0);
        step(4'h0, 4'b0111, 70, 71, 72, 0, 1'b0);
        check("wrap_push_count", int'(freeCount), 64);
        repeat (15) pop4();
        check("wrap_read_count", int'(freeCount), 4);
        check("wrap_read_free0", int'(freeReg[0]), 94);
        check("wrap_read_free1", int'(freeReg[1]), 70);
        check("wrap_read_free2", int'(freeReg[2]), 71);
        check("wrap_read_free3", int'(freeReg[3]), 72);

        // Simultaneous pop 2 / push 4 at count 10
        doReset();
        repeat (14) pop4();
        step(4'h0, 4'b1001, 32, 0, 0, 33, 1'b0);
        check("mix_pre_count", int'(freeCount), 10);
        step(4'b1010, 4'hF, 34, 35, 36, 37, 1'b0);
        check("mix_count", int'(freeCount), 12);
        check("mix_free0", int'(freeReg[0]), 90);

        // Recovery with pushes and ignored requests
        doReset();
        repeat (4) pop4();
        step(4'b0101, 4'h0, 0, 0, 0, 0, 1'b0);
        step(4'b1010, 4'h0, 0, 0, 0, 0, 1'b0);
        check("rec_pre_count", int'(freeCount), 44);
        step(4'h0, 4'b0111, 32, 33, 34, 0, 1'b0);
        step(4'h0, 4'b1110, 0, 35, 36, 37, 1'b0);
        check("rec_pre2_count", int'(freeCount), 50);
        step(4'hF, 4'b0011, 38, 39, 0, 0, 1'b1);
        check("rec_count", int'(freeCount), 64);
        check("rec_empty", int'(freeListEmpty), 0);
        check("rec_free0", int'(freeReg[0]), 40);
        step(4'h0, 4'h0, 0, 0, 0, 0, 1'b0);
        pop4();
        check("rec_pop_free0", int'(freeReg[0]), 44);

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
